// File: rtl/lsu_ctrl.sv
// Load/store controller: one memory operation at a time over a req/gnt/rvalid bus,
// with byte-lane alignment of stores and extraction/extension of load data.
module lsu_ctrl (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [1:0]  size_i,
   input  logic        sign_ext_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic [4:0]  rf_waddr_i,
   output logic        ready_o,
   output logic        data_req_o,
   input  logic        data_gnt_i,
   output logic [31:0] data_addr_o,
   output logic        data_we_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] data_wdata_o,
   input  logic        data_rvalid_i,
   input  logic [31:0] data_rdata_i,
   input  logic        data_err_i,
   output logic        rf_we_o,
   output logic [4:0]  rf_waddr_o,
   output logic [31:0] rf_wdata_o,
   output logic        done_o,
   output logic        err_o,
   output logic        err_misaligned_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        sext_q, sext_d;
   logic [1:0]  off_q, off_d;
   logic [4:0]  waddr_q, waddr_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic        err_q, err_d;
   logic        mis_q, mis_d;
   logic [31:0] rf_wdata_q, rf_wdata_d;
   logic        acc_mis_s;

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      logic res;
      case (size)
         2'b00:   res = (off != 2'b00);
         2'b01:   res = off[0];
         2'b10:   res = 1'b0;
         default: res = 1'b1;
      endcase
      return res;
   endfunction

   function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] res;
      case (size)
         2'b00:   res = 4'b1111;
         2'b01:   res = 4'b0011 << off;
         2'b10:   res = 4'b0001 << off;
         default: res = 4'b0000;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
      logic [31:0] res;
      case (size)
         2'b01:   res = {wd[15:0], wd[15:0]};
         2'b10:   res = {4{wd[7:0]}};
         default: res = wd;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] load_extract(input logic [31:0] rd, input logic [1:0] size,
                                                input logic [1:0] off, input logic sext);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      case (off)
         2'b00:   b = rd[7:0];
         2'b01:   b = rd[15:8];
         2'b10:   b = rd[23:16];
         default: b = rd[31:24];
      endcase
      h = off[1] ? rd[31:16] : rd[15:0];
      case (size)
         2'b10:   res = {{24{sext & b[7]}}, b};
         2'b01:   res = {{16{sext & h[15]}}, h};
         default: res = rd;
      endcase
      return res;
   endfunction

   assign acc_mis_s = is_misaligned(size_i, addr_i[1:0]);

   // Next-state and operation-context capture.
   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      size_d     = size_q;
      sext_d     = sext_q;
      off_d      = off_q;
      waddr_d    = waddr_q;
      addr_d     = addr_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      err_d      = err_q;
      mis_d      = mis_q;
      rf_wdata_d = rf_wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (req_i) begin
               we_d    = we_i;
               size_d  = size_i;
               sext_d  = sext_i_s();
               off_d   = addr_i[1:0];
               waddr_d = rf_waddr_i;
               addr_d  = {addr_i[31:2], 2'b00};
               be_d    = byte_en(size_i, addr_i[1:0]);
               wdata_d = store_data(size_i, wdata_i);
               err_d   = acc_mis_s;
               mis_d   = acc_mis_s;
               state_d = acc_mis_s ? ST_DONE : ST_REQ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (data_gnt_i) begin
               state_d = ST_WAIT;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_WAIT: begin
            if (data_rvalid_i) begin
               err_d      = data_err_i;
               mis_d      = 1'b0;
               rf_wdata_d = load_extract(data_rdata_i, size_q, off_q, sext_q);
               state_d    = ST_DONE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   function automatic logic sext_i_s();
      return sign_ext_i;
   endfunction

   // State and context registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         we_q       <= 1'b0;
         size_q     <= 2'b00;
         sext_q     <= 1'b0;
         off_q      <= 2'b00;
         waddr_q    <= 5'd0;
         addr_q     <= 32'd0;
         be_q       <= 4'd0;
         wdata_q    <= 32'd0;
         err_q      <= 1'b0;
         mis_q      <= 1'b0;
         rf_wdata_q <= 32'd0;
      end else begin
         state_q    <= state_d;
         we_q       <= we_d;
         size_q     <= size_d;
         sext_q     <= sext_d;
         off_q      <= off_d;
         waddr_q    <= waddr_d;
         addr_q     <= addr_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         err_q      <= err_d;
         mis_q      <= mis_d;
         rf_wdata_q <= rf_wdata_d;
      end
   end

   // Outputs come only from state and registers, never from the data_* inputs.
   assign ready_o          = (state_q == ST_IDLE);
   assign data_req_o       = (state_q == ST_REQ);
   assign data_addr_o      = addr_q;
   assign data_we_o        = we_q;
   assign data_be_o        = be_q;
   assign data_wdata_o     = wdata_q;
   assign done_o           = (state_q == ST_DONE);
   assign err_o            = done_o & err_q;
   assign err_misaligned_o = done_o & mis_q;
   assign rf_we_o          = done_o & ~we_q & ~err_q;
   assign rf_waddr_o       = waddr_q;
   assign rf_wdata_o       = rf_wdata_q;

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller directly downstream of the issue stage in the synchronous RV32I pipeline. It accepts one memory operation at a time:

- the request, write-enable and store data come from issue;
- the effective address comes from the ALU result.

It drives the data-memory request/grant/rvalid bus, aligns byte enables and store data, and extracts and extends load data. It returns load results to the register-file write port and reports misaligned or bus errors.

## Interface
Parameters: none (32-bit data and address are fixed).

- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- req_i  in  1  operation request from issue (data_req_o)
- we_i  in  1  1 = store, 0 = load
- size_i  in  2  access size: 00 word, 01 half, 10 byte, 11 illegal
- sign_ext_i  in  1  load sign-extension (LB/LH = 1, LBU/LHU = 0)
- addr_i  in  32  effective address (ALU result)
- wdata_i  in  32  store data (issue lsu_wdata_o)
- rf_waddr_i  in  5  load destination register
- ready_o  out  1  high in IDLE; an operation is accepted when req_i && ready_o
- data_req_o  out  1  memory request
- data_gnt_i  in  1  memory grant
- data_addr_o  out  32  word-aligned address, addr_i with bits [1:0] cleared
- data_we_o  out  1  memory write enable
- data_be_o  out  4  byte enables
- data_wdata_o  out  32  lane-replicated store data
- data_rvalid_i  in  1  response valid
- data_rdata_i  in  32  read data
- data_err_i  in  1  bus error, qualified by data_rvalid_i
- rf_we_o  out  1  one-cycle register-file write pulse
- rf_waddr_o  out  5  write address
- rf_wdata_o  out  32  extended load data
- done_o  out  1  one-cycle completion pulse (success or error)
- err_o  out  1  one-cycle error pulse, coincident with done_o
- err_misaligned_o  out  1  qualifies err_o: 1 = misaligned/illegal size, 0 = bus error

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - ready_o = 1.
  - On acceptance, latch we, size, sign_ext, offset addr_i[1:0], rf_waddr_i, data_addr_o, data_be_o, data_wdata_o.
  - Aligned access -> REQ. Misaligned access -> DONE with error.
- Misaligned: half with offset[0] = 1; word with offset != 0; size 11 always. No bus request is issued.
- Byte enables:
  - word: 1111
  - half: 0011 << offset
  - byte: 0001 << offset
- Store data:
  - word: as-is
  - half: {wdata[15:0], wdata[15:0]}
  - byte: wdata[7:0] replicated to all 4 lanes
- REQ: data_req_o = 1, with address, be, we and wdata held stable until data_gnt_i. On grant -> WAIT. data_req_o drops the cycle after the grant.
- WAIT: wait for data_rvalid_i. data_rvalid_i arriving in the same cycle as the grant is not expected and is ignored. On rvalid -> DONE, capturing rdata and err.
- DONE (one cycle):
  - done_o = 1.
  - Bus error: err_o = 1, err_misaligned_o = 0, no RF write.
  - Load without error: rf_we_o = 1, rf_wdata_o = extracted lane, sign- or zero-extended per sign_ext.
  - Store: rf_we_o = 0.
  - Always returns to IDLE.
- Load extraction: byte = rdata[8*offset +: 8]; half = rdata[16*offset[1] +: 16]; word = rdata.
- data_rvalid_i and data_gnt_i are ignored in IDLE and DONE; stray responses are dropped.
- req_i is ignored when ready_o = 0. Issue must hold or re-present the request.

## Timing
- Reset values: state IDLE, ready_o = 1. All other outputs 0: data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o, rf_we_o, rf_waddr_o, rf_wdata_o, done_o, err_o, err_misaligned_o.
- Reset during REQ or WAIT aborts immediately. Any response arriving after reset is dropped in IDLE.
- All outputs are registered or decoded from state only; there is no combinational path from the data_* inputs to any output.
- Aligned op accepted at edge N: data_req_o high in cycle N+1.
- Grant in cycle G: data_req_o low in cycle G+1.
- rvalid in cycle R: done_o and rf_we_o high in cycle R+1; ready_o high again in cycle R+2.
- Minimum aligned latency (grant in N+1, rvalid in N+2): done_o in N+3. Throughput is one op per 4 cycles minimum.
- Misaligned op accepted at edge N: done_o, err_o and err_misaligned_o high in cycle N+1, with no data_req_o at any point. ready_o high again in N+2.
- rf_waddr_o and rf_wdata_o are valid whenever rf_we_o = 1.

## Test plan
- LW, addr 0x1000, rdata 0xDEADBEEF, gnt in the first request cycle, rvalid the next cycle -> data_be_o = 1111, data_addr_o = 0x1000; done_o, rf_we_o and rf_wdata_o = 0xDEADBEEF three cycles after acceptance.
- LB/LBU at addr 0x1003, rdata 0x80xxxxxx -> be = 1000; LB writes 0xFFFFFF80, LBU writes 0x00000080. LH at 0x1002, rdata 0x8001xxxx -> be = 1100, result 0xFFFF8001.
- SB at addr 0x2001, wdata 0x000000A5, gnt delayed 3 cycles -> be = 0010, wdata_o = 0xA5A5A5A5, request signals stable for all 4 request cycles; done_o with no rf_we_o.
- LW at 0x1002 and LH at 0x1001 -> no data_req_o; done_o, err_o and err_misaligned_o one cycle after acceptance; ready_o returns.
- Load returning data_err_i = 1 -> err_o = 1, err_misaligned_o = 0, rf_we_o = 0.
- Assert rst_ni low in WAIT, then deliver rvalid after release -> all outputs at reset values, response dropped. A new req_i accepted afterwards completes normally.
